// File: rtl/demux4_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer: lane selects,
// lane state encoding and the select-to-one-hot decode.
package demux4_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [1:0] LANE0 = 2'b00;
    localparam logic [1:0] LANE1 = 2'b01;
    localparam logic [1:0] LANE2 = 2'b10;
    localparam logic [1:0] LANE3 = 2'b11;

    localparam logic LANE_EMPTY = 1'b0;
    localparam logic LANE_FULL  = 1'b1;

    // Unknown selects decode to no lane so an idle X never reaches a lane.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] sel);
        case (sel)
            LANE0:   return 4'b0001;
            LANE1:   return 4'b0010;
            LANE2:   return 4'b0100;
            LANE3:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/demux4_lane.sv
// One-entry output register for a single demux lane with valid/ready handshake.
// Optional transfer counter is built only when DEMUX4_STATS_EN is defined.
module demux4_lane
    import demux4_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
`ifdef DEMUX4_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    logic state;

    assign valid = (state == LANE_FULL);

    // A write is only issued when the lane is empty or draining, so it always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LANE_EMPTY;
            data  <= '0;
        end else if (wr) begin
            state <= LANE_FULL;
            data  <= wr_data;
        end else if ((state == LANE_FULL) && ready) begin
            state <= LANE_EMPTY;
        end
    end

`ifdef DEMUX4_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (valid && ready) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 registered stream demultiplexer with per-lane back-pressure and broadcast.
// Optional per-lane transfer counters: define DEMUX4_STATS_EN.
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     d,
    input  logic [1:0]           s,
    input  logic                 bcast,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     y0,
    output logic [WIDTH-1:0]     y1,
    output logic [WIDTH-1:0]     y2,
    output logic [WIDTH-1:0]     y3,
    output logic [NUM_LANES-1:0] y_valid,
    input  logic [NUM_LANES-1:0] y_ready
`ifdef DEMUX4_STATS_EN
    ,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1,
    output logic [CNT_W-1:0]     cnt2,
    output logic [CNT_W-1:0]     cnt3
`endif
);

    logic [NUM_LANES-1:0] lane_ok;
    logic [NUM_LANES-1:0] sel_hot;
    logic [NUM_LANES-1:0] wr_en;
    logic                 accept;
    logic [WIDTH-1:0]     lane_data [NUM_LANES];
`ifdef DEMUX4_STATS_EN
    logic [CNT_W-1:0]     lane_cnt  [NUM_LANES];
`endif

    // Broadcast is all-or-nothing: it waits until every lane can take the word.
    always_comb begin
        lane_ok  = ~y_valid | y_ready;
        sel_hot  = lane_onehot(s);
        in_ready = bcast ? (&lane_ok) : (|(sel_hot & lane_ok));
        accept   = in_valid & in_ready;
        wr_en    = '0;
        if (accept) begin
            wr_en = bcast ? {NUM_LANES{1'b1}} : sel_hot;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        demux4_lane #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr      (wr_en[i]),
            .wr_data (d),
            .ready   (y_ready[i]),
            .valid   (y_valid[i]),
            .data    (lane_data[i])
`ifdef DEMUX4_STATS_EN
            ,
            .cnt     (lane_cnt[i])
`endif
        );
    end

    assign y0 = lane_data[0];
    assign y1 = lane_data[1];
    assign y2 = lane_data[2];
    assign y3 = lane_data[3];

`ifdef DEMUX4_STATS_EN
    assign cnt0 = lane_cnt[0];
    assign cnt1 = lane_cnt[1];
    assign cnt2 = lane_cnt[2];
    assign cnt3 = lane_cnt[3];
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed vector table, corner-case
// sequences and randomized traffic against a lane-level reference model.
module tb_demux4_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
    logic             bcast;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y0, y1, y2, y3;
    logic [3:0]       y_valid;
    logic [3:0]       y_ready;
`ifdef DEMUX4_STATS_EN
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-lane occupancy, held word and handshake count.
    logic             m_valid [4];
    logic [WIDTH-1:0] m_data  [4];
    logic [CNT_W-1:0] m_cnt   [4];

    typedef struct {
        logic             iv;
        logic [1:0]       sel;
        logic             bc;
        logic [WIDTH-1:0] din;
        logic [3:0]       yr;
        logic             exp_ready;
        logic [3:0]       exp_valid;
        logic [31:0]      exp_y;
    } vec_t;

    vec_t vecs [11];

    demux4_stream #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .s        (s),
        .bcast    (bcast),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y_valid  (y_valid),
        .y_ready  (y_ready)
`ifdef DEMUX4_STATS_EN
        ,
        .cnt0     (cnt0),
        .cnt1     (cnt1),
        .cnt2     (cnt2),
        .cnt3     (cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] dut_y(input int i);
        case (i)
            0:       return y0;
            1:       return y1;
            2:       return y2;
            default: return y3;
        endcase
    endfunction

`ifdef DEMUX4_STATS_EN
    function automatic logic [CNT_W-1:0] dut_cnt(input int i);
        case (i)
            0:       return cnt0;
            1:       return cnt1;
            2:       return cnt2;
            default: return cnt3;
        endcase
    endfunction
`endif

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
            m_cnt[i]   = '0;
        end
    endtask

    function automatic logic model_in_ready();
        int free_lanes = 0;
        for (int i = 0; i < 4; i++) begin
            if (!m_valid[i] || y_ready[i]) free_lanes++;
        end
        if (bcast) return (free_lanes == 4);
        return (!m_valid[s] || y_ready[s]);
    endfunction

    // Applies the rules for one rising edge using the inputs present at that edge.
    task automatic modelUpdate();
        logic take;
        take = in_valid && model_in_ready();
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && y_ready[i]) m_cnt[i] = m_cnt[i] + 1'b1;
            if (take && (bcast || (int'(s) == i))) begin
                m_valid[i] = 1'b1;
                m_data[i]  = d;
            end else if (y_ready[i]) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [1:0] sel, input logic bc,
                                 input logic [WIDTH-1:0] din, input logic [3:0] yr);
        in_valid = iv;
        s        = sel;
        bcast    = bc;
        d        = din;
        y_ready  = yr;
    endtask

    task automatic checkOutput(input string tag);
        for (int i = 0; i < 4; i++) begin
            checkVal($sformatf("%s_valid%0d", tag, i), 32'(y_valid[i]), 32'(m_valid[i]));
            checkVal($sformatf("%s_y%0d", tag, i), 32'(dut_y(i)), 32'(m_data[i]));
`ifdef DEMUX4_STATS_EN
            checkVal($sformatf("%s_cnt%0d", tag, i), 32'(dut_cnt(i)), 32'(m_cnt[i]));
`endif
        end
    endtask

    // One full cycle: check in_ready mid-cycle, clock, then check registered outputs.
    task automatic tick(input string tag);
        @(negedge clk);
        checkVal({tag, "_in_ready"}, 32'(in_ready), 32'(model_in_ready()));
        @(posedge clk);
        modelUpdate();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        // {iv, s, bcast, d, y_ready, exp in_ready, exp y_valid after edge, exp {y3,y2,y1,y0}}
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 8'hA5, 4'b0000, 1'b1, 4'b0100, 32'h00A50000};
        vecs[1]  = '{1'b1, 2'b10, 1'b0, 8'h77, 4'b0000, 1'b0, 4'b0100, 32'h00A50000};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 8'h0F, 4'b0000, 1'b1, 4'b0101, 32'h00A5000F};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 8'h11, 4'b0000, 1'b1, 4'b0111, 32'h00A5110F};
        vecs[4]  = '{1'b1, 2'b01, 1'b0, 8'h22, 4'b0010, 1'b1, 4'b0111, 32'h00A5220F};
        vecs[5]  = '{1'b1, 2'b11, 1'b0, 8'h99, 4'b0000, 1'b1, 4'b1111, 32'h99A5220F};
        vecs[6]  = '{1'b1, 2'b00, 1'b1, 8'h3C, 4'b0000, 1'b0, 4'b1111, 32'h99A5220F};
        vecs[7]  = '{1'b1, 2'b00, 1'b1, 8'h3C, 4'b0111, 1'b0, 4'b1000, 32'h99A5220F};
        vecs[8]  = '{1'b1, 2'b00, 1'b1, 8'h3C, 4'b1000, 1'b1, 4'b1111, 32'h3C3C3C3C};
        vecs[9]  = '{1'b0, 2'b01, 1'b0, 8'hEE, 4'b1111, 1'b1, 4'b0000, 32'h3C3C3C3C};
        vecs[10] = '{1'b0, 2'b10, 1'b1, 8'hEE, 4'b0000, 1'b1, 4'b0000, 32'h3C3C3C3C};

        rst_n = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 4'b0000);
        modelReset();
        #12;
        checkVal("reset_y_valid", 32'(y_valid), 32'h0);
        checkVal("reset_y_all", {y3, y2, y1, y0}, 32'h0);
        checkVal("reset_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 11; k++) begin
            applyStimulus(vecs[k].iv, vecs[k].sel, vecs[k].bc, vecs[k].din, vecs[k].yr);
            @(negedge clk);
            checkVal($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(vecs[k].exp_ready));
            @(posedge clk);
            modelUpdate();
            #1;
            checkVal($sformatf("vec%0d_y_valid", k), 32'(y_valid), 32'(vecs[k].exp_valid));
            checkVal($sformatf("vec%0d_y", k), {y3, y2, y1, y0}, vecs[k].exp_y);
        end

        // Back-pressure: lane 0 must hold its word while other inputs churn.
        applyStimulus(1'b1, 2'b00, 1'b0, 8'h5A, 4'b0000);
        tick("bp_load");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 2'($urandom), 1'b0, 8'($urandom), 4'b1110);
            tick("bp_hold");
            checkVal("bp_hold_y0", 32'(y0), 32'h5A);
            checkVal("bp_hold_v0", 32'(y_valid[0]), 32'h1);
        end

        // Asynchronous reset in the middle of a cycle with three lanes occupied.
        applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 4'b1111);
        tick("ar_drain");
        applyStimulus(1'b1, 2'b00, 1'b0, 8'hA0, 4'b0000);
        tick("ar_fill0");
        applyStimulus(1'b1, 2'b01, 1'b0, 8'hB1, 4'b0000);
        tick("ar_fill1");
        applyStimulus(1'b1, 2'b11, 1'b0, 8'hD3, 4'b0000);
        tick("ar_fill3");
        checkVal("ar_pre_valid", 32'(y_valid), 32'hB);
        applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkVal("ar_y_valid", 32'(y_valid), 32'h0);
        checkVal("ar_y_all", {y3, y2, y1, y0}, 32'h0);
        checkVal("ar_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ar_after");

`ifdef DEMUX4_STATS_EN
        // 257 lane-0 handshakes: the counter wraps once and lands on 1.
        for (int k = 0; k < 257; k++) begin
            applyStimulus(1'b1, 2'b00, 1'b0, 8'(k), 4'b0001);
            tick("st_stream");
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 4'b0001);
        tick("st_last");
        checkVal("st_cnt0", 32'(cnt0), 32'd1);
        checkVal("st_cnt123", {8'h0, cnt3, cnt2, cnt1}, 32'h0);
`endif

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(3) != 0), 2'($urandom), ($urandom_range(7) == 0),
                          8'($urandom), 4'($urandom));
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
